// File: rtl/text_console_ctrl.sv
// Console command sequencer: turns accepted CPU console commands into
// character-buffer writes and runs the clear-screen and scroll-up engines.
//
// state  | meaning
// IDLE   | accepting commands, cursor updates and single char writes
// CLEAR  | writing 0x00 to every cell, row-major
// SC_RD  | reading source cell (r+LINE_STEP, c) for the scroll copy
// SC_WR  | writing the returned read data to (r, c)
// SC_CLR | blanking the bottom LINE_STEP rows after the copy
module text_console_ctrl #(
    parameter int COLS      = 80,
    parameter int ROWS      = 60,
    parameter int LINE_STEP = 2,
    parameter int COL_W     = 7,
    parameter int ROW_W     = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_ADDR,
    input  logic [7:0]       CMD_DATA,
    output logic             FB_WE,
    output logic [ROW_W-1:0] FB_WROW,
    output logic [COL_W-1:0] FB_WCOL,
    output logic [7:0]       FB_WDATA,
    output logic             FB_RE,
    output logic [ROW_W-1:0] FB_RROW,
    output logic [COL_W-1:0] FB_RCOL,
    input  logic [7:0]       FB_RDATA,
    output logic [COL_W-1:0] CURSOR_X,
    output logic [ROW_W-1:0] CURSOR_Y,
    output logic             BUSY
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] SC_RD  = 3'd2;
    localparam logic [2:0] SC_WR  = 3'd3;
    localparam logic [2:0] SC_CLR = 3'd4;

    localparam logic [COL_W-1:0] X_MAX     = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] Y_MAX     = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] STEP      = ROW_W'(LINE_STEP);
    localparam logic [ROW_W-1:0] COPY_LAST = ROW_W'(ROWS - LINE_STEP - 1);
    localparam logic [ROW_W-1:0] BLANK_1ST = ROW_W'(ROWS - LINE_STEP);
    localparam logic [ROW_W:0]   ROWS_EXT  = (ROW_W + 1)'(ROWS);

    logic [2:0]       state_q, state_d;
    logic [COL_W-1:0] cur_x_q, cur_x_d;
    logic [ROW_W-1:0] cur_y_q, cur_y_d;
    logic [ROW_W-1:0] er_q, er_d;
    logic [COL_W-1:0] ec_q, ec_d;
    logic             we_q, we_d;
    logic [ROW_W-1:0] wrow_q, wrow_d;
    logic [COL_W-1:0] wcol_q, wcol_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             wsel_rd_q, wsel_rd_d;
    logic             re_q, re_d;
    logic [ROW_W-1:0] rrow_q, rrow_d;
    logic [COL_W-1:0] rcol_q, rcol_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             do_nl;
    logic             last_col;
    logic [ROW_W-1:0] nxt_er;
    logic [COL_W-1:0] nxt_ec;

    assign CMD_READY = (state_q == IDLE) && !RST;
    assign accept    = CMD_VALID && CMD_READY;
    assign last_col  = (ec_q == X_MAX);
    assign nxt_ec    = last_col ? '0 : ec_q + COL_W'(1);
    assign nxt_er    = last_col ? er_q + ROW_W'(1) : er_q;

    always_comb begin
        state_d   = state_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        er_d      = er_q;
        ec_d      = ec_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        wsel_rd_d = 1'b0;
        wrow_d    = wrow_q;
        wcol_d    = wcol_q;
        wdata_d   = wdata_q;
        rrow_d    = rrow_q;
        rcol_d    = rcol_q;
        do_nl     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (CMD_ADDR)
                        2'b00: begin
                            case (CMD_DATA)
                                8'h0D: cur_x_d = '0;
                                8'h0A: do_nl = 1'b1;
                                8'h08: begin
                                    if (cur_x_q != '0) cur_x_d = cur_x_q - COL_W'(1);
                                end
                                default: begin
                                    we_d    = 1'b1;
                                    wrow_d  = cur_y_q;
                                    wcol_d  = cur_x_q;
                                    wdata_d = CMD_DATA;
                                    if (cur_x_q == X_MAX) begin
                                        cur_x_d = '0;
                                        do_nl   = 1'b1;
                                    end else begin
                                        cur_x_d = cur_x_q + COL_W'(1);
                                    end
                                end
                            endcase
                        end
                        2'b01: begin
                            cur_x_d = '0;
                            cur_y_d = '0;
                            er_d    = '0;
                            ec_d    = '0;
                            state_d = CLEAR;
                        end
                        2'b10: cur_x_d = (CMD_DATA > 8'(COLS - 1)) ? X_MAX : COL_W'(CMD_DATA);
                        default: cur_y_d = (CMD_DATA > 8'(ROWS - 1)) ? Y_MAX : ROW_W'(CMD_DATA);
                    endcase
                end
            end
            CLEAR, SC_CLR: begin
                if (er_q == Y_MAX && last_col) begin
                    state_d = IDLE;
                end else begin
                    er_d = nxt_er;
                    ec_d = nxt_ec;
                end
            end
            SC_RD: state_d = SC_WR;
            SC_WR: begin
                if (er_q == COPY_LAST && last_col) begin
                    state_d = SC_CLR;
                    er_d    = BLANK_1ST;
                    ec_d    = '0;
                end else begin
                    state_d = SC_RD;
                    er_d    = nxt_er;
                    ec_d    = nxt_ec;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bottom-of-screen newline keeps Y and hands off to the scroll engine.
        if (do_nl) begin
            if ({1'b0, cur_y_q} + {1'b0, STEP} >= ROWS_EXT) begin
                state_d = SC_RD;
                er_d    = '0;
                ec_d    = '0;
            end else begin
                cur_y_d = cur_y_q + STEP;
            end
        end

        // Engine strobes are derived from the state being entered so they
        // line up with that state's cycle.
        case (state_d)
            CLEAR, SC_CLR: begin
                we_d    = 1'b1;
                wrow_d  = er_d;
                wcol_d  = ec_d;
                wdata_d = 8'h00;
            end
            SC_WR: begin
                we_d      = 1'b1;
                wrow_d    = er_d;
                wcol_d    = ec_d;
                wsel_rd_d = 1'b1;
            end
            SC_RD: begin
                re_d   = 1'b1;
                rrow_d = er_d + STEP;
                rcol_d = ec_d;
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            er_q      <= '0;
            ec_q      <= '0;
            we_q      <= 1'b0;
            wrow_q    <= '0;
            wcol_q    <= '0;
            wdata_q   <= '0;
            wsel_rd_q <= 1'b0;
            re_q      <= 1'b0;
            rrow_q    <= '0;
            rcol_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            er_q      <= er_d;
            ec_q      <= ec_d;
            we_q      <= we_d;
            wrow_q    <= wrow_d;
            wcol_q    <= wcol_d;
            wdata_q   <= wdata_d;
            wsel_rd_q <= wsel_rd_d;
            re_q      <= re_d;
            rrow_q    <= rrow_d;
            rcol_q    <= rcol_d;
            busy_q    <= busy_d;
        end
    end

    assign FB_WE    = we_q;
    assign FB_WROW  = wrow_q;
    assign FB_WCOL  = wcol_q;
    // Scroll copy data arrives from the RAM during SC_WR itself, so it is
    // steered straight through rather than re-registered.
    assign FB_WDATA = wsel_rd_q ? FB_RDATA : wdata_q;
    assign FB_RE    = re_q;
    assign FB_RROW  = rrow_q;
    assign FB_RCOL  = rcol_q;
    assign CURSOR_X = cur_x_q;
    assign CURSOR_Y = cur_y_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl: a screen-image and cursor model
// plus a per-cycle compare thread, with a character RAM behind the DUT.
module tb_text_console_ctrl;

    localparam int COLS = 80;
    localparam int ROWS = 60;
    localparam int LS   = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [1:0] CMD_ADDR;
    logic [7:0] CMD_DATA;
    logic       FB_WE;
    logic [5:0] FB_WROW;
    logic [6:0] FB_WCOL;
    logic [7:0] FB_WDATA;
    logic       FB_RE;
    logic [5:0] FB_RROW;
    logic [6:0] FB_RCOL;
    logic [7:0] FB_RDATA;
    logic [6:0] CURSOR_X;
    logic [5:0] CURSOR_Y;
    logic       BUSY;

    text_console_ctrl dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
        .FB_WE(FB_WE), .FB_WROW(FB_WROW), .FB_WCOL(FB_WCOL), .FB_WDATA(FB_WDATA),
        .FB_RE(FB_RE), .FB_RROW(FB_RROW), .FB_RCOL(FB_RCOL), .FB_RDATA(FB_RDATA),
        .CURSOR_X(CURSOR_X), .CURSOR_Y(CURSOR_Y), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Character RAM: one-cycle read latency, preload fills row r with r.
    logic [7:0] ram [ROWS][COLS];
    logic       preload = 1'b0;
    always @(posedge CLK) begin
        if (preload) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    ram[r][c] <= 8'(r);
        end else begin
            if (FB_RE) FB_RDATA <= ram[FB_RROW][FB_RCOL];
            if (FB_WE) ram[FB_WROW][FB_WCOL] <= FB_WDATA;
        end
    end

    typedef struct {int r; int c; int d;} wr_t;

    int         tests = 0;
    int         fails = 0;
    int         exp_x = 0;
    int         exp_y = 0;
    int         busy_left = 0;
    int         busy_dut = 0;
    int         eng_we = 0;
    logic [7:0] mfb [ROWS*COLS];
    wr_t        wq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic model_newline();
        if (exp_y + LS >= ROWS) begin
            for (int i = 0; i < (ROWS - LS) * COLS; i++) mfb[i] = mfb[i + LS * COLS];
            for (int i = (ROWS - LS) * COLS; i < ROWS * COLS; i++) mfb[i] = 8'h00;
            busy_left = 2 * (ROWS - LS) * COLS + LS * COLS;
        end else begin
            exp_y = exp_y + LS;
        end
    endtask

    task automatic model_apply(input logic [1:0] a, input logic [7:0] d);
        case (a)
            2'b00: begin
                if (d == 8'h0D) exp_x = 0;
                else if (d == 8'h0A) model_newline();
                else if (d == 8'h08) begin
                    if (exp_x > 0) exp_x = exp_x - 1;
                end else begin
                    wq.push_back('{exp_y, exp_x, int'(d)});
                    mfb[exp_y * COLS + exp_x] = d;
                    if (exp_x == COLS - 1) begin
                        exp_x = 0;
                        model_newline();
                    end else begin
                        exp_x = exp_x + 1;
                    end
                end
            end
            2'b01: begin
                exp_x = 0;
                exp_y = 0;
                for (int i = 0; i < ROWS * COLS; i++) mfb[i] = 8'h00;
                busy_left = ROWS * COLS;
            end
            2'b10: exp_x = (int'(d) > COLS - 1) ? COLS - 1 : int'(d);
            default: exp_y = (int'(d) > ROWS - 1) ? ROWS - 1 : int'(d);
        endcase
    endtask

    task automatic compare_cycle();
        wr_t w;
        chk("cmd_ready", CMD_READY, (!RST && busy_left == 0));
        chk("busy", BUSY, busy_left != 0);
        chk("cursor_x", CURSOR_X, exp_x);
        chk("cursor_y", CURSOR_Y, exp_y);
        if (FB_WE && FB_RE)
            chk("rw_same_cell", (FB_WROW == FB_RROW && FB_WCOL == FB_RCOL), 0);
        if (wq.size() > 0) begin
            w = wq.pop_front();
            chk("char_we", FB_WE, 1);
            chk("char_row", FB_WROW, w.r);
            chk("char_col", FB_WCOL, w.c);
            chk("char_data", FB_WDATA, w.d);
        end else if (busy_left == 0) begin
            chk("idle_we", FB_WE, 0);
            chk("idle_re", FB_RE, 0);
        end else if (FB_WE) begin
            eng_we++;
        end
        if (BUSY) busy_dut++;
        if (busy_left > 0) busy_left--;
    endtask

    task automatic send(input logic [1:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_ADDR  = a;
        CMD_DATA  = d;
        while (!CMD_READY && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        if (!CMD_READY) begin
            chk("accept_timeout", 1, 0);
            CMD_VALID = 1'b0;
        end else begin
            @(posedge CLK);
            #1;
            CMD_VALID = 1'b0;
            model_apply(a, d);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_left > 0 && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        if (busy_left > 0) chk("idle_timeout", 1, 0);
        @(negedge CLK);
        @(negedge CLK);
    endtask

    function automatic int image_errs();
        int e = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (ram[r][c] !== mfb[r * COLS + c]) e++;
        return e;
    endfunction

    initial begin
        int b0, w0;
        RST       = 1'b1;
        CMD_VALID = 1'b0;
        CMD_ADDR  = 2'b00;
        CMD_DATA  = 8'h00;
        for (int i = 0; i < ROWS * COLS; i++) mfb[i] = 8'h00;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready", CMD_READY, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_we", FB_WE, 0);
        chk("rst_re", FB_RE, 0);
        chk("rst_x", CURSOR_X, 0);
        chk("rst_y", CURSOR_Y, 0);
        chk("rst_waddr", {FB_WROW, FB_WCOL, FB_WDATA}, 0);
        #1 RST = 1'b0;

        fork
            forever begin
                @(negedge CLK);
                compare_cycle();
            end
        join_none

        // Back-to-back printable characters.
        send(2'b00, 8'h41);
        send(2'b00, 8'h42);
        @(negedge CLK);
        chk("ab_x", CURSOR_X, 2);

        // Wrap at the right edge, then CR/LF/BS from column 0.
        send(2'b10, 8'd79);
        send(2'b11, 8'd10);
        send(2'b00, 8'h5A);
        @(negedge CLK);
        chk("wrap_x", CURSOR_X, 0);
        chk("wrap_y", CURSOR_Y, 12);
        send(2'b00, 8'h0D);
        send(2'b00, 8'h0A);
        send(2'b00, 8'h08);
        @(negedge CLK);
        chk("ctl_x", CURSOR_X, 0);
        chk("ctl_y", CURSOR_Y, 14);

        send(2'b10, 8'd200);
        send(2'b11, 8'd99);
        @(negedge CLK);
        chk("clamp_x", CURSOR_X, 79);
        chk("clamp_y", CURSOR_Y, 59);

        // Clear with a following command held valid throughout.
        b0 = busy_dut;
        w0 = eng_we;
        send(2'b01, 8'h00);
        send(2'b00, 8'h51);
        wait_idle();
        chk("clear_busy_cycles", busy_dut - b0, 4800);
        chk("clear_writes", eng_we - w0, 4800);
        chk("clear_image", image_errs(), 0);
        chk("clear_then_x", CURSOR_X, 1);

        // Scroll from a preloaded screen via LF on row 58.
        @(negedge CLK);
        preload = 1'b1;
        @(negedge CLK);
        preload = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mfb[r * COLS + c] = 8'(r);
        send(2'b11, 8'd58);
        b0 = busy_dut;
        w0 = eng_we;
        send(2'b00, 8'h0A);
        wait_idle();
        chk("scroll_busy_cycles", busy_dut - b0, 9440);
        chk("scroll_writes", eng_we - w0, 4800);
        chk("scroll_image", image_errs(), 0);
        chk("scroll_r0", ram[0][0], 2);
        chk("scroll_r57", ram[57][79], 59);
        chk("scroll_r58", ram[58][0], 0);
        chk("scroll_r59", ram[59][79], 0);
        chk("scroll_y", CURSOR_Y, 58);

        // Printable char wrapping on the bottom row: write plus scroll.
        send(2'b10, 8'd79);
        send(2'b00, 8'h57);
        wait_idle();
        chk("wrapscroll_image", image_errs(), 0);
        chk("wrapscroll_w", ram[56][79], 8'h57);
        chk("wrapscroll_r54", ram[54][0], 58);
        chk("wrapscroll_x", CURSOR_X, 0);
        chk("wrapscroll_y", CURSOR_Y, 58);

        // Reset 100 cycles into a scroll.
        send(2'b00, 8'h0A);
        repeat (100) @(posedge CLK);
        #2 RST = 1'b1;
        @(posedge CLK);
        #1;
        busy_left = 0;
        exp_x = 0;
        exp_y = 0;
        wq.delete();
        @(negedge CLK);
        chk("abort_we", FB_WE, 0);
        chk("abort_re", FB_RE, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_cursor", {CURSOR_Y, CURSOR_X}, 0);
        @(posedge CLK);
        #2 RST = 1'b0;
        @(negedge CLK);
        chk("abort_ready", CMD_READY, 1);
        send(2'b00, 8'h45);
        repeat (3) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/text_console_ctrl.md
# text_console_ctrl

Command sequencer that owns the write port of the 80x60 text-mode character buffer. It accepts decoded CPU console commands over a valid/ready handshake and turns them into framebuffer cell writes. It tracks the cursor, handles CR/LF/backspace and line wrap, and runs the multi-cycle clear-screen and scroll-up engines. It sits between the CPU bus capture logic and the dual-port character RAM read by the VGA scan-out path, in the pixel clock domain.

## Interface
Parameters:
- COLS, 80, characters per row
- ROWS, 60, character rows
- LINE_STEP, 2, rows advanced per newline/wrap and rows moved per scroll
- COL_W, 7, column index width
- ROW_W, 6, row index width

Ports:
- CLK  in  1  pixel clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  controller can accept a command this cycle
- CMD_ADDR  in  2  00 char/control, 01 clear screen, 10 set cursor X, 11 set cursor Y
- CMD_DATA  in  8  character code or cursor value
- FB_WE  out  1  framebuffer write strobe
- FB_WROW / FB_WCOL  out  ROW_W / COL_W  write address
- FB_WDATA  out  8  write data
- FB_RE  out  1  framebuffer read strobe (scroll only)
- FB_RROW / FB_RCOL  out  ROW_W / COL_W  read address
- FB_RDATA  in  8  read data, valid the cycle after FB_RE
- CURSOR_X / CURSOR_Y  out  COL_W / ROW_W  current cursor
- BUSY  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, CLEAR, SC_RD, SC_WR, SC_CLR.
- CMD_READY = (state == IDLE) && !RST. A command is accepted when CMD_VALID && CMD_READY.
- Accepted ADDR 00, by data:
  - 0x0D: X := 0.
  - 0x0A: newline.
  - 0x08: X := X-1, saturating at 0; no write.
  - Any other value: write CMD_DATA at (Y,X), then X := X+1. If the old X == COLS-1, X := 0 and a newline follows.
- Newline: if Y + LINE_STEP >= ROWS, Y is unchanged and the block enters SC_RD. Otherwise Y := Y + LINE_STEP. X is unchanged by a bare LF.
- ADDR 01: X,Y := 0 and the block enters CLEAR.
- ADDR 10: X := min(CMD_DATA, COLS-1). ADDR 11: Y := min(CMD_DATA, ROWS-1). Neither writes the framebuffer.
- CLEAR: writes 0x00 to every cell, row-major from (0,0) to (ROWS-1,COLS-1), one cell per cycle. Then returns to IDLE with cursor (0,0).
- Scroll, per destination cell (r,c) for r in 0..ROWS-LINE_STEP-1, row-major:
  - SC_RD issues a read of (r+LINE_STEP,c).
  - SC_WR writes FB_RDATA to (r,c).
- After the last copy, SC_CLR writes 0x00 to rows ROWS-LINE_STEP..ROWS-1, one cell per cycle. Then the block returns to IDLE; the cursor is unchanged by the scroll.
- Engine counters are internal and separate from the cursor. All arithmetic is unsigned at COL_W/ROW_W width; comparisons are done before increment, so the cursor never wraps past its range.
- Reset values: state IDLE, CURSOR_X/Y 0, FB_WE 0, FB_RE 0, BUSY 0, FB_WDATA/addresses 0.
- Reset mid-CLEAR or mid-scroll aborts the sequence immediately. The framebuffer contents are left partial; no recovery is attempted.

## Timing
- All outputs except CMD_READY are registered.
- Command accepted at edge N:
  - FB_WE and address/data, if any, are valid in cycle N+1.
  - CURSOR_X/Y reflect the new value in N+1.
- Back-to-back char/control/cursor commands are accepted every cycle (throughput 1/clk).
- A command that triggers CLEAR or scroll drops CMD_READY and raises BUSY from N+1. For a printable char that wraps at the bottom row, the char write in N+1 coincides with the first FB_RE.
- SC_RD/SC_WR alternate every cycle. FB_RE is high in SC_RD; FB_WE is high in SC_WR.
- Durations (defaults):
  - CLEAR: exactly ROWS*COLS = 4800 cycles of FB_WE.
  - Scroll: 2*(ROWS-LINE_STEP)*COLS + LINE_STEP*COLS = 9440 cycles.
  - CMD_READY returns high the cycle after the last write.
- FB_WE and FB_RE never target the same cell in the same cycle.

## Test plan
- Reset, then chars 'A','B' in consecutive cycles -> FB writes (0,0)=0x41, (0,1)=0x42 on consecutive cycles; CURSOR_X=2, CMD_READY never drops.
- Set X=79, Y=10, write 'Z' -> write (10,79)=0x5A; cursor (12,0). Then 0x0D, 0x0A, 0x08 from X=0 -> cursor stays X=0, Y=14; no FB writes.
- Set X=200 and Y=99 -> cursor clamps to (59,79).
- Clear command -> exactly 4800 FB_WE pulses covering all cells with 0x00; BUSY high for 4800 cycles; cursor (0,0); CMD_VALID held high is ignored until done.
- Preload row r with value r, set Y=58, send 0x0A:
  - Row r ends holding r+2 for r < 58; rows 58-59 hold 0x00.
  - 9440 busy cycles; cursor Y stays 58.
- Assert RST 100 cycles into a scroll -> next cycle: IDLE, FB_WE=FB_RE=0, cursor (0,0), CMD_READY=1 after RST falls.
